input_debounce_filter: RTL and testbench
========================================

INPUT_DEBOUNCE_FILTER -- requirements
Module: input_debounce_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on in_raw; legal range 2..4.
REQ-002 Parameter STABLE_CNT, default 4: consecutive agreeing samples needed to change in_clean; legal range 2..255.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_raw  input  1  asynchronous raw level from the pad or button.
REQ-006 sample_en  input  1  sampling strobe; the FSM and counter advance only when it is 1.
REQ-007 clr_glitch  input  1  synchronous clear of glitch_cnt.
REQ-008 in_clean  output  1  debounced level; drives the `in` input of the downstream two-state FSM.
REQ-009 rise  output  1  one-cycle pulse when in_clean goes 0->1.
REQ-010 fall  output  1  one-cycle pulse when in_clean goes 1->0.
REQ-011 glitch_cnt  output  8  count of rejected pulses, saturating.

Function
REQ-012 in_raw SHALL pass through SYNC_STAGES flops clocked every cycle, independent of sample_en; the last stage is called sync.
REQ-013 The FSM SHALL have four states: LOW, LOW_CHK, HIGH, HIGH_CHK; in_clean = 1 in HIGH and HIGH_CHK, 0 otherwise.
REQ-014 LOW, sample_en=1, sync=1 -> LOW_CHK, stable counter = 1; otherwise hold.
REQ-015 LOW_CHK, sample_en=1, sync=1: counter+1; the edge on which the counter would reach STABLE_CNT -> HIGH, rise=1 that cycle.
REQ-016 LOW_CHK, sample_en=1, sync=0 -> LOW, counter = 0, glitch_cnt +1.
REQ-017 HIGH/HIGH_CHK SHALL mirror REQ-014..016 with sync polarity inverted; HIGH_CHK -> LOW asserts fall.
REQ-018 With sample_en held at 1, in_clean SHALL change on the (SYNC_STAGES+STABLE_CNT)-th rising edge, counting the first edge that samples the new in_raw level.
REQ-019 With sample_en=0, state, counter and outputs SHALL hold; rise/fall SHALL be 0.
REQ-020 rise, fall and the in_clean change SHALL be registered and coincident; rise and fall SHALL never be 1 together.
REQ-021 glitch_cnt SHALL saturate at 255 and never wrap.
REQ-022 If clr_glitch=1 and a glitch occur in the same cycle, glitch_cnt SHALL become 0 (clear wins).
REQ-023 The stable counter width SHALL be 8 bits; it SHALL never exceed STABLE_CNT.

Reset
REQ-024 On reset=1 at a clock edge: state=LOW, counter=0, in_clean=0, rise=0, fall=0, glitch_cnt=0, all sync flops=0.
REQ-025 A reset asserted mid-check SHALL abort the check without pulsing rise/fall or incrementing glitch_cnt.
REQ-026 Reset SHALL take precedence over sample_en and clr_glitch.

Structure
REQ-027 A shared package debounce_pkg SHALL hold the state encodings (LOW, LOW_CHK, HIGH, HIGH_CHK as 2-bit constants) and GLITCH_MAX = 255.
REQ-028 The synchronizer SHALL be a sub-module sync_chain (parameter SYNC_STAGES, ports clk, reset, d, q).
REQ-029 The FSM next-state logic SHALL be combinational; all outputs SHALL come directly from flops.

Verification (defaults, sample_en=1 unless stated)
REQ-030 Step 0->1 on in_raw held for 20 cycles -> in_clean=1 and rise=1 on the 6th edge; no glitch counted.
REQ-031 1-cycle and 3-cycle high pulses on in_raw -> in_clean stays 0, glitch_cnt=2, no rise.
REQ-032 sample_en=1 every 4th cycle, in_raw steps high -> in_clean rises after 4 strobed samples, following the 2-cycle sync delay.
REQ-033 300 glitches -> glitch_cnt=255; then clr_glitch coincident with a glitch -> glitch_cnt=0.
REQ-034 reset asserted while in LOW_CHK with counter=3 -> next cycle state LOW, in_clean=0, rise=0, glitch_cnt unchanged at 0.
REQ-035 High-to-low step after a settled high -> fall=1 on the 6th edge, in_clean=0 on the same edge.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared encodings and limits for the input debounce filter.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        LOW_CHK  = 2'b01,
        HIGH     = 2'b10,
        HIGH_CHK = 2'b11
    } state_e;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous level input.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d};
    assign q      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/input_debounce_filter.sv
// Debounces a raw pad level: synchronize, then require STABLE_CNT
// consecutive agreeing strobed samples before changing in_clean.
module input_debounce_filter
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_raw,
    input  logic       sample_en,
    input  logic       clr_glitch,
    output logic       in_clean,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CNT - 1);

    logic       sync;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       clean_q, clean_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [7:0] glitch_q, glitch_d;
    logic       glitch_ev;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (in_raw),
        .q    (sync)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitch_ev = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                LOW: begin
                    if (sync) begin
                        state_d = LOW_CHK;
                        cnt_d   = 8'd1;
                    end
                end
                LOW_CHK: begin
                    if (!sync) begin
                        state_d   = LOW;
                        cnt_d     = 8'd0;
                        glitch_ev = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        // Counter is cleared instead of reaching STABLE_CNT.
                        state_d = HIGH;
                        cnt_d   = 8'd0;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HIGH: begin
                    if (!sync) begin
                        state_d = HIGH_CHK;
                        cnt_d   = 8'd1;
                    end
                end
                HIGH_CHK: begin
                    if (sync) begin
                        state_d   = HIGH;
                        cnt_d     = 8'd0;
                        glitch_ev = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = LOW;
                        cnt_d   = 8'd0;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
        glitch_d = glitch_q;
        if (clr_glitch) begin
            glitch_d = 8'd0;
        end else if (glitch_ev && glitch_q != GLITCH_MAX) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOW;
            cnt_q    <= 8'd0;
            clean_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign in_clean   = clean_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debounce_filter.sv
// Randomized and directed bench for input_debounce_filter.
module tb_input_debounce_filter;

    localparam int SYNC = 2;
    localparam int STAB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_raw;
    logic       sample_en;
    logic       clr_glitch;
    logic       in_clean;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: synchronizer delay line plus a count of
    // consecutive strobed samples disagreeing with the clean level.
    logic m_sync [SYNC];
    logic m_clean;
    logic m_rise;
    logic m_fall;
    int   m_run;
    int   m_glitch;

    input_debounce_filter #(
        .SYNC_STAGES(SYNC),
        .STABLE_CNT (STAB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_raw    (in_raw),
        .sample_en (sample_en),
        .clr_glitch(clr_glitch),
        .in_clean  (in_clean),
        .rise      (rise),
        .fall      (fall),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic raw, input logic en,
                        input logic clr, input logic rst);
        logic s;
        logic ev;
        in_raw     = raw;
        sample_en  = en;
        clr_glitch = clr;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_clean  = 1'b0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            s      = m_sync[SYNC-1];
            ev     = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en) begin
                if (s != m_clean) begin
                    m_run++;
                    if (m_run == STAB) begin
                        m_clean = s;
                        m_rise  = s;
                        m_fall  = !s;
                        m_run   = 0;
                    end
                end else if (m_run > 0) begin
                    m_run = 0;
                    ev    = 1'b1;
                end
            end
            if (clr) m_glitch = 0;
            else if (ev && m_glitch < 255) m_glitch++;
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = raw;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({in_clean, rise, fall, glitch_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset: got clean=%b rise=%b fall=%b gc=%0d want all 0",
                     in_clean, rise, fall, glitch_cnt);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_step_rise();
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (rise !== (e == 6) || in_clean !== (e >= 6) ||
                fall !== 1'b0 || glitch_cnt !== 8'd0) begin
                errors++;
                $display("FAIL step_rise edge %0d: got clean=%b rise=%b fall=%b gc=%0d want clean=%b rise=%b",
                         e, in_clean, rise, fall, glitch_cnt, e >= 6, e == 6);
            end
        end
    endtask

    task automatic test_step_fall();
        for (int e = 1; e <= 12; e++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (fall !== (e == 6) || in_clean !== (e < 6) || rise !== 1'b0) begin
                errors++;
                $display("FAIL step_fall edge %0d: got clean=%b rise=%b fall=%b want clean=%b fall=%b",
                         e, in_clean, rise, fall, e < 6, e == 6);
            end
        end
    endtask

    task automatic test_glitches();
        logic seen_rise;
        seen_rise = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            seen_rise |= rise;
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            seen_rise |= rise;
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            seen_rise |= rise;
        end
        checks++;
        if (glitch_cnt !== 8'd2 || in_clean !== 1'b0 || seen_rise !== 1'b0) begin
            errors++;
            $display("FAIL glitches: got gc=%0d clean=%b rise_seen=%b want gc=2 clean=0 rise_seen=0",
                     glitch_cnt, in_clean, seen_rise);
        end
    endtask

    task automatic test_strobe();
        int rises;
        int strobes_high;
        rises        = 0;
        strobes_high = 0;
        for (int c = 0; c < 48; c++) begin
            if ((c % 4) == 3 && m_sync[SYNC-1] && !m_clean) strobes_high++;
            tick(1'b1, (c % 4) == 3, 1'b0, 1'b0);
            checks++;
            if (in_clean !== m_clean || rise !== m_rise || fall !== 1'b0) begin
                errors++;
                $display("FAIL strobe cyc %0d: got clean=%b rise=%b want clean=%b rise=%b",
                         c, in_clean, rise, m_clean, m_rise);
            end
            if (rise === 1'b1) begin
                rises++;
                checks++;
                if (strobes_high != STAB) begin
                    errors++;
                    $display("FAIL strobe_count: rose after %0d samples want %0d",
                             strobes_high, STAB);
                end
            end
        end
        checks++;
        if (rises != 1 || in_clean !== 1'b1) begin
            errors++;
            $display("FAIL strobe_final: got rises=%0d clean=%b want 1 1", rises, in_clean);
        end
    endtask

    task automatic test_saturate();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 300; g++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (glitch_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate: got gc=%0d want 255", glitch_cnt);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_wins: got gc=%0d want 0", glitch_cnt);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL after_clr: got gc=%0d want 1", glitch_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 5; e++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (in_clean !== 1'b0 || rise !== 1'b0 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: got clean=%b rise=%b gc=%0d want 0 0 0",
                     in_clean, rise, glitch_cnt);
        end
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (rise !== (e == 6) || glitch_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_mid_restart edge %0d: got rise=%b gc=%0d want rise=%b gc=0",
                         e, rise, glitch_cnt, e == 6);
            end
        end
    endtask

    task automatic test_random();
        logic raw;
        int   hold;
        raw  = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                raw  = ~raw;
                hold = $urandom_range(1, 9);
            end
            hold--;
            tick(raw, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 499) == 0));
            checks++;
            if (in_clean !== m_clean || rise !== m_rise || fall !== m_fall ||
                glitch_cnt !== 8'(m_glitch) || (rise & fall) !== 1'b0) begin
                errors++;
                $display("FAIL random cyc %0d: got clean=%b rise=%b fall=%b gc=%0d want clean=%b rise=%b fall=%b gc=%0d",
                         c, in_clean, rise, fall, glitch_cnt,
                         m_clean, m_rise, m_fall, m_glitch);
            end
        end
    endtask

    initial begin
        in_raw     = 1'b0;
        sample_en  = 1'b0;
        clr_glitch = 1'b0;
        reset      = 1'b1;
        test_reset();
        test_step_rise();
        test_step_fall();
        test_glitches();
        test_strobe();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
